inst_fetch: RTL and testbench

//  Fetch stage upstream of the CPU datapath: drives instruction-memory addresses, captures read data

---
 rtl/riscv_pkg.sv | 12 +
 rtl/inst_fetch_if.sv | 21 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/inst_fetch.sv | 64 ++++++
 tb/tb_inst_fetch.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared CPU definitions used by the fetch stage and its bench.
package riscv_pkg;
    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;
    localparam logic [31:0]     INST_NOP = 32'h0000_0013;
    localparam int              FE_W     = XLEN * 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory, decode handshake and redirect input.
interface inst_fetch_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_inst,
        input  imem_rdata, out_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_inst,
        output imem_rdata, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch queue of {pc, inst} entries with flush; pointers wrap naturally (DEPTH is 2^n).
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && full && !pop && !flush));
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: issues sequential imem reads, queues returned words, hands {pc, inst} to decode.
module inst_fetch #(
    parameter  int              XLEN     = riscv_pkg::XLEN,
    parameter  logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter  int              DEPTH    = 4,
    localparam int              AW       = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    inst_fetch_if.master   bus
);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc, pc_q;
    logic              req_q, kill;
    logic              issue, push, pop;
    logic [AW:0]       count;
    logic              empty, full;
    logic [2*XLEN-1:0] dout;
    logic [AW+1:0]     outstanding;

    // A word in flight reserves a slot; a same-cycle pop earns no credit.
    assign outstanding = {1'b0, count} + (AW+2)'(req_q);
    assign issue = reset && !bus.redirect_valid && (outstanding < DEPTH_W);
    assign push  = req_q && !kill && !bus.redirect_valid;
    assign pop   = !empty && bus.out_ready && !bus.redirect_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            pc_q     <= '0;
            req_q    <= 1'b0;
            kill     <= 1'b0;
        end else begin
            req_q <= issue;
            kill  <= bus.redirect_valid;
            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            end else if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                pc_q     <= fetch_pc;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   ({pc_q, bus.imem_rdata}),
        .dout  (dout),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = empty ? '0 : dout[2*XLEN-1 -: XLEN];
    assign bus.out_inst  = empty ? '0 : dout[XLEN-1:0];
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random ready/redirect traffic against a program-order model.
module tb_inst_fetch;
    import riscv_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if #(.XLEN(XLEN)) bus();

    inst_fetch #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous instruction memory: word for the address sampled at the previous edge.
    always @(posedge clk) bus.imem_rdata <= bus.imem_req ? word_at(bus.imem_addr) : INST_NOP;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decode sees consecutive words from the latest restart point, each exactly once.
    fetch_entry_t exp_q[$];
    logic [31:0]  gen_pc, req_pc;
    int           cyc = 0, req_cnt = 0, xfers = 0;
    int           first_req = -1, first_val = -1;
    logic         prev_hold = 1'b0, prev_redir = 1'b0;
    logic [31:0]  prev_pc, prev_inst;

    task automatic restart_model(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = pc;
        req_pc = pc;
        for (int i = 0; i < 2*DEPTH; i++) begin
            exp_q.push_back('{pc: gen_pc, inst: word_at(gen_pc)});
            gen_pc += 32'd4;
        end
    endtask

    always @(negedge clk) begin
        fetch_entry_t e;
        cyc++;
        if (!reset) begin
            chk("rst_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_req",   64'(bus.imem_req),  64'd0);
            chk("rst_addr",  64'(bus.imem_addr), 64'(RPC));
            chk("rst_pc",    64'(bus.out_pc),    64'd0);
            chk("rst_inst",  64'(bus.out_inst),  64'd0);
            restart_model(RPC);
            req_cnt = 0; first_req = -1; first_val = -1;
            prev_hold = 1'b0; prev_redir = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_pc",    64'(bus.out_pc),    64'(prev_pc));
                chk("hold_inst",  64'(bus.out_inst),  64'(prev_inst));
            end
            if (prev_redir) chk("redir_flush_valid", 64'(bus.out_valid), 64'd0);
            if (bus.redirect_valid) begin
                chk("redir_req", 64'(bus.imem_req), 64'd0);
                restart_model({bus.redirect_pc[31:2], 2'b00});
            end else begin
                if (bus.imem_req) begin
                    chk("req_addr", 64'(bus.imem_addr), 64'(req_pc));
                    req_pc += 32'd4;
                    req_cnt++;
                    if (first_req < 0) first_req = cyc;
                end
                if (bus.out_valid && first_val < 0) first_val = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back('{pc: gen_pc, inst: word_at(gen_pc)});
                        gen_pc += 32'd4;
                    end
                    e = exp_q.pop_front();
                    chk("out_pc",   64'(bus.out_pc),   64'(e.pc));
                    chk("out_inst", 64'(bus.out_inst), 64'(e.inst));
                    xfers++;
                end
            end
            prev_hold  = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            prev_redir = bus.redirect_valid;
            prev_pc    = bus.out_pc;
            prev_inst  = bus.out_inst;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step(1);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int x0;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        step(3);

        // Reset release, free-flowing decode
        reset = 1'b1;
        step(12);
        chk("t1_latency", 64'(first_val - first_req), 64'd2);
        chk("t1_xfers",   64'(xfers >= 9), 64'd1);

        // Decode stalled from the start: queue fills, then drains in order
        reset = 1'b0; bus.out_ready = 1'b0;
        step(1);
        reset = 1'b1;
        step(8);
        chk("t2_req_cnt", 64'(req_cnt), 64'd4);
        chk("t2_valid",   64'(bus.out_valid), 64'd1);
        chk("t2_pc",      64'(bus.out_pc), 64'd0);
        bus.out_ready = 1'b1;
        step(20);

        // Redirect while a word is being handed over
        chk("t4_pre_valid", 64'(bus.out_valid), 64'd1);
        x0 = xfers;
        redirect(32'h0000_0102);
        chk("t4_no_xfer", 64'(xfers), 64'(x0));
        chk("t4_empty",   64'(bus.out_valid), 64'd0);
        step(15);

        // Wrap past the top of the address space, then back-to-back redirects
        redirect(32'hFFFF_FFF8);
        step(10);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
        step(1);
        bus.redirect_pc = 32'h0000_0301;
        step(1);
        bus.redirect_valid = 1'b0;
        step(10);

        // Asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_req",   64'(bus.imem_req),  64'd0);
        chk("t6_addr",  64'(bus.imem_addr), 64'(RPC));
        chk("t6_pc",    64'(bus.out_pc),    64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(12);

        // Random decode back-pressure and redirects
        for (int i = 0; i < 1500; i++) begin
            bus.out_ready      = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 31) == 0);
            bus.redirect_pc    = $urandom;
            step(1);
        end
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        step(10);
        chk("traffic_flowed", 64'(xfers > 700), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
